// File: rtl/lifo_pkg.sv
// Shared definitions for the LIFO drain controller: FSM states and output buffer sizing.
package lifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_POP   = 2'd1,
    ST_FLUSH = 2'd2
  } drain_state_e;

  localparam int unsigned BUF_DEPTH = 2;
  // Occupancy counts 0..BUF_DEPTH.
  localparam int unsigned OCC_W     = 2;

endpackage

// File: rtl/lifo_skid_buf.sv
// Two-entry FIFO carrying {last, data} words; entry 0 is the head presented downstream.
module lifo_skid_buf
  import lifo_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [W-1:0]     push_data_i,
  input  logic             push_last_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [W-1:0]     data_o,
  output logic             last_o,
  output logic [OCC_W-1:0] occ_o
);

  logic [W:0]       e0_q, e0_d;
  logic [W:0]       e1_q, e1_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [W:0]       push_ent;
  logic             pop;

  assign valid_o  = (occ_q != '0);
  assign data_o   = e0_q[W-1:0];
  assign last_o   = e0_q[W];
  assign occ_o    = occ_q;
  assign pop      = valid_o & ready_i;
  assign push_ent = {push_last_i, push_data_i};

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    occ_d = occ_q;
    unique case ({push_i, pop})
      2'b10: begin
        if (occ_q == '0) begin
          e0_d  = push_ent;
          occ_d = occ_q + 1'b1;
        end else if (occ_q == OCC_W'(1)) begin
          e1_d  = push_ent;
          occ_d = occ_q + 1'b1;
        end
      end
      2'b01: begin
        e0_d  = e1_q;
        occ_d = occ_q - 1'b1;
      end
      2'b11: begin
        // Simultaneous push and pop keeps occupancy; the new word lands behind any survivor.
        if (occ_q == OCC_W'(1)) begin
          e0_d = push_ent;
        end else begin
          e0_d = e1_q;
          e1_d = push_ent;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= '0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      occ_q <= occ_d;
    end
  end

endmodule

// File: rtl/lifo_drain_ctrl.sv
// Burst-drain controller: pops a LIFO on command and streams the words out with m_last and a done count.
// Handshakes: a transfer happens on any cycle where valid & ready are both high; valid holds until then.
module lifo_drain_ctrl
  import lifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  input  logic [CNT_WIDTH-1:0]  cmd_len,
  output logic                  cmd_ready,
  output logic                  lifo_rd_en,
  input  logic [DATA_WIDTH-1:0] lifo_data_rd,
  input  logic                  lifo_empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  done_cnt
);

  drain_state_e         state_q, state_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 count_mode_q, count_mode_d;
  logic                 inflight_q, inflight_d;

  logic [OCC_W-1:0]     occ;
  logic [OCC_W:0]       pend;
  logic                 buf_pop;
  logic                 room;
  logic                 issue;
  logic                 cap_last;

  lifo_skid_buf #(
    .W (DATA_WIDTH)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (lifo_data_rd),
    .push_last_i (cap_last),
    .ready_i     (m_ready),
    .valid_o     (m_valid),
    .data_o      (m_data),
    .last_o      (m_last),
    .occ_o       (occ)
  );

  assign buf_pop = m_valid & m_ready;
  assign pend    = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_q};
  // A beat leaving this cycle frees the slot the new pop will need two edges from now.
  assign room    = (pend < (OCC_W+1)'(BUF_DEPTH)) | buf_pop;
  assign issue   = (state_q == ST_POP) & ~rst & ~lifo_empty
                 & (~count_mode_q | (rem_q != '0)) & room;
  // lifo_empty already reflects the in-flight pop, so it marks the word being captured as final.
  assign cap_last = (count_mode_q & (rem_q == '0)) | lifo_empty;

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    cnt_d        = cnt_q;
    count_mode_d = count_mode_q;
    inflight_d   = issue;
    cmd_ready    = 1'b0;
    lifo_rd_en   = issue;
    done         = 1'b0;
    done_cnt     = '0;

    if (issue) begin
      if (count_mode_q) rem_d = rem_q - 1'b1;
      if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_d = cnt_q + 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = ~rst;
        if (cmd_valid & ~rst) begin
          rem_d        = cmd_len;
          cnt_d        = '0;
          count_mode_d = (cmd_len != '0);
          state_d      = ST_POP;
        end
      end
      ST_POP: begin
        if (inflight_q & cap_last) begin
          state_d = ST_FLUSH;
        end else if (lifo_empty & ~inflight_q & (cnt_q == '0)) begin
          done    = ~rst;
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (buf_pop & m_last) begin
          done     = ~rst;
          done_cnt = cnt_q;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rem_q        <= '0;
      cnt_q        <= '0;
      count_mode_q <= 1'b0;
      inflight_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      cnt_q        <= cnt_d;
      count_mode_q <= count_mode_d;
      inflight_q   <= inflight_d;
    end
  end

endmodule
